md_unit_e: RTL and testbench



---
 rtl/md_unit_e_pkg.sv | 31 +++
 rtl/md_unit_e_if.sv | 15 +
 rtl/md_unit_e_arith.sv | 56 +++++
 rtl/md_unit_e.sv | 93 +++++++++
 tb/tb_md_unit_e.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/md_unit_e_pkg.sv
// Shared pipeline constants for the E-stage multiply/divide unit.
// Holds the md_op encodings that the controller and hazard unit also use.
package md_unit_e_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle run.
    function automatic logic is_md_run_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_e_if.sv
// Bundle between the E stage and the multiply/divide unit.
// master = pipeline side, slave = md_unit_e.
interface md_unit_e_if;
    logic        Req;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output Req, md_op, A, B, input start, busy, hi, lo);
    modport slave  (input Req, md_op, A, B, output start, busy, hi, lo);
endinterface

// File: rtl/md_unit_e_arith.sv
// Combinational HI/LO result for mult/multu/div/divu.
// Divide by zero passes the current HI/LO through unchanged.
module md_arith
    import md_unit_e_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;

    // Sign-extended 64-bit operands give the signed product in the low 64 bits.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; 0x80000000/-1 wraps back to 0x80000000.
    assign sgn     = (op == MD_DIV);
    assign a_mag   = (sgn && a[31]) ? -a : a;
    assign b_mag   = (sgn && b[31]) ? -b : b;
    assign divisor = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign q       = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    assign r       = (sgn && a[31]) ? -r_mag : r_mag;

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = r;
                    res_lo = q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit_e.sv
// E-stage multiply/divide unit: architectural HI/LO plus a fixed-latency
// busy window so the hazard unit can stall later HI/LO users in D.
module md_unit_e
    import md_unit_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_unit_e_if.slave  md
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      phi_q, phi_d;
    logic [31:0]      plo_q, plo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             start;

    md_arith u_arith (
        .op     (md.md_op),
        .a      (md.A),
        .b      (md.B),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign start    = is_md_run_op(md.md_op) && !md.Req && (state_q == S_IDLE);
    assign md.start = start;
    assign md.busy  = (state_q == S_RUN);
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    phi_d   = res_hi;
                    plo_d   = res_lo;
                    cnt_d   = is_div_op(md.md_op) ? DIV_CNT : MULT_CNT;
                    state_d = S_RUN;
                end else if (!md.Req) begin
                    if (md.md_op == MD_MTHI) hi_d = md.A;
                    if (md.md_op == MD_MTLO) lo_d = md.A;
                end
            end
            S_RUN: begin
                // Req is ignored here: the owning instruction already committed.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e: latency, arithmetic corner cases, Req and reset.
module tb_md_unit_e;
    import md_unit_e_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    md_unit_e_if ifc ();

    md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch a run op and verify the busy window is exactly n cycles with
    // HI/LO frozen. req_at / mtlo_at inject Req or an MTLO at that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] old_hi,
                          input logic [31:0] old_lo, input int req_at, input int mtlo_at);
        ifc.md_op = op; ifc.A = a; ifc.B = b; ifc.Req = 1'b0;
        #1;
        check({tag, " start"}, 32'(ifc.start), 32'd1);
        tick();
        ifc.md_op = MD_NONE;
        for (int i = 1; i <= n; i++) begin
            ifc.Req = (i == req_at);
            if (i == mtlo_at) begin
                ifc.md_op = MD_MTLO; ifc.A = 32'h1234;
            end else begin
                ifc.md_op = MD_NONE;
            end
            #1;
            check({tag, " busy"}, 32'(ifc.busy), 32'd1);
            if (i == 1 || i == n) begin
                check({tag, " hi held"}, ifc.hi, old_hi);
                check({tag, " lo held"}, ifc.lo, old_lo);
            end
            tick();
        end
        ifc.Req = 1'b0; ifc.md_op = MD_NONE;
        check({tag, " busy done"}, 32'(ifc.busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ifc.Req = 1'b0; ifc.md_op = MD_NONE; ifc.A = '0; ifc.B = '0;
        #12;
        check("rst busy", 32'(ifc.busy), 32'd0);
        check("rst hi", ifc.hi, 32'd0);
        check("rst lo", ifc.lo, 32'd0);
        check("rst start", 32'(ifc.start), 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'd0, 32'd0, 0, 0);
        check("mult hi", ifc.hi, 32'hFFFFFFFF);
        check("mult lo", ifc.lo, 32'hFFFFFFFA);

        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        check("div hi", ifc.hi, 32'hFFFFFFFF);
        check("div lo", ifc.lo, 32'hFFFFFFFD);

        run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        check("divu hi", ifc.hi, 32'd1);
        check("divu lo", ifc.lo, 32'h7FFFFFFC);

        run_op("div ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd1, 32'h7FFFFFFC, 0, 0);
        check("div ovf hi", ifc.hi, 32'd0);
        check("div ovf lo", ifc.lo, 32'h80000000);

        // MTHI/MTLO: single edge, no busy.
        ifc.md_op = MD_MTHI; ifc.A = 32'h11;
        #1;
        check("mthi start", 32'(ifc.start), 32'd0);
        tick();
        check("mthi hi", ifc.hi, 32'h11);
        check("mthi busy", 32'(ifc.busy), 32'd0);
        ifc.md_op = MD_MTLO; ifc.A = 32'h22;
        tick();
        check("mtlo lo", ifc.lo, 32'h22);
        ifc.md_op = MD_NONE;

        run_op("divu0", MD_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22, 0, 0);
        check("divu0 hi", ifc.hi, 32'h11);
        check("divu0 lo", ifc.lo, 32'h22);

        // Req in the issue cycle flushes both run ops and moves.
        ifc.md_op = MD_MULTU; ifc.A = 32'd3; ifc.B = 32'd4; ifc.Req = 1'b1;
        #1;
        check("req start", 32'(ifc.start), 32'd0);
        tick();
        check("req busy", 32'(ifc.busy), 32'd0);
        check("req hi", ifc.hi, 32'h11);
        check("req lo", ifc.lo, 32'h22);
        ifc.md_op = MD_MTHI; ifc.A = 32'hDEAD;
        tick();
        check("req mthi", ifc.hi, 32'h11);
        ifc.Req = 1'b0; ifc.md_op = MD_NONE;

        run_op("mult req", MD_MULT, 32'd7, 32'd6, 5, 32'h11, 32'h22, 2, 0);
        check("mult req hi", ifc.hi, 32'd0);
        check("mult req lo", ifc.lo, 32'd42);

        run_op("multu mtlo", MD_MULTU, 32'd2, 32'd5, 5, 32'd0, 32'd42, 0, 2);
        check("busy mtlo lo", ifc.lo, 32'd10);
        check("busy mtlo hi", ifc.hi, 32'd0);
        ifc.md_op = MD_MTLO; ifc.A = 32'h1234;
        tick();
        check("mtlo idle lo", ifc.lo, 32'h1234);
        check("mtlo idle busy", 32'(ifc.busy), 32'd0);
        ifc.md_op = MD_NONE;

        // Async reset mid-DIV.
        ifc.md_op = MD_DIV; ifc.A = 32'd100; ifc.B = 32'd7;
        tick();
        ifc.md_op = MD_NONE;
        tick();
        tick();
        check("pre-rst busy", 32'(ifc.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async busy", 32'(ifc.busy), 32'd0);
        check("async hi", ifc.hi, 32'd0);
        check("async lo", ifc.lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_op("mult post", MD_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd0, 0, 0);
        check("mult post hi", ifc.hi, 32'd0);
        check("mult post lo", ifc.lo, 32'd6);

        // Back-to-back: start accepted the cycle busy falls.
        run_op("b2b", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'd0, 32'd6, 0, 0);
        check("b2b hi", ifc.hi, 32'hFFFFFFFE);
        check("b2b lo", ifc.lo, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
